// File: rtl/softmax_pkg.sv
// rtl/softmax_pkg.sv - shared constants and types for the softmax datapath
//
// Purpose : element width, buffer index width, max-subtract FSM state
//           encoding and the element typedef, shared by the softmax stages.
// Contents: DATALENGTH, INPUTMAX, BUF_DEPTH, state_e, data_t.
package softmax_pkg;

    localparam int DATALENGTH = 32;
    localparam int INPUTMAX   = 5;
    localparam int BUF_DEPTH  = 1 << INPUTMAX;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        LOAD = 2'b01,
        PREP = 2'b10,
        EMIT = 2'b11
    } state_e;

    typedef logic signed [DATALENGTH-1:0] data_t;

endpackage

// File: rtl/softmax_vecbuf.sv
// rtl/softmax_vecbuf.sv - vector element register file, 1 sync write / 1 async read
//
// Purpose : holds one score vector between loading and replay. Contents are
//           not reset; readers only look at entries written for the current
//           vector.
// Ports   : clk_i     - clock
//           we_i      - write enable
//           waddr_i   - write index
//           wdata_i   - write data
//           raddr_i   - read index
//           rdata_o   - read data (combinational)
module softmax_vecbuf #(
    parameter int W  = 32,
    parameter int AW = 5
) (
    input  logic          clk_i,
    input  logic          we_i,
    input  logic [AW-1:0] waddr_i,
    input  logic [W-1:0]  wdata_i,
    input  logic [AW-1:0] raddr_i,
    output logic [W-1:0]  rdata_o
);

    localparam int DEPTH = 1 << AW;

    logic [W-1:0] mem_q [DEPTH];

    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/softmax_maxsub.sv
// rtl/softmax_maxsub.sv - softmax stabilisation: capture vector, subtract its max
//
// Purpose : loads 1..32 signed scores while tracking their maximum, then
//           replays each element as x[i] - max in original order so the
//           downstream exponentiation only sees non-positive arguments.
// Config  : SOFTMAX_MAXSUB_SAT_EN defined   -> differences below -2^31 clamp
//                                             to the most negative value.
//           SOFTMAX_MAXSUB_SAT_EN undefined -> low DATALENGTH bits (wrap).
// Ports   : Clock    - clock, rising edge
//           Reset    - synchronous active-low reset
//           Datain   - input element, InValid/InReady handshake
//           N        - vector length minus one, sampled with the first element
//           Dataout  - x[i] - max, OutValid/OutReady handshake
//           OutLast  - marks the final element of the vector
module softmax_maxsub
    import softmax_pkg::*;
#(
    parameter int DATALENGTH = softmax_pkg::DATALENGTH,
    parameter int INPUTMAX   = softmax_pkg::INPUTMAX
) (
    input  logic                  Clock,
    input  logic                  Reset,
    input  logic [DATALENGTH-1:0] Datain,
    input  logic                  InValid,
    output logic                  InReady,
    input  logic [INPUTMAX-1:0]   N,
    output logic [DATALENGTH-1:0] Dataout,
    output logic                  OutValid,
    input  logic                  OutReady,
    output logic                  OutLast
);

    localparam logic [INPUTMAX-1:0] IDX_ONE = INPUTMAX'(1);

    state_e                  state_q, state_d;
    logic [INPUTMAX-1:0]     len_q, len_d;
    logic [INPUTMAX-1:0]     wr_q, wr_d;
    logic [INPUTMAX-1:0]     rd_q, rd_d;
    logic [DATALENGTH-1:0]   max_q, max_d;
    logic [DATALENGTH-1:0]   dout_q, dout_d;
    logic                    ovalid_q, ovalid_d;
    logic                    olast_q, olast_d;

    logic                    in_fire;
    logic                    out_fire;
    logic                    buf_we;
    logic [INPUTMAX-1:0]     buf_waddr;
    logic [INPUTMAX-1:0]     buf_raddr;
    logic [DATALENGTH-1:0]   buf_rdata;
    logic [DATALENGTH-1:0]   diff_res;

    assign InReady  = (state_q == IDLE) || (state_q == LOAD);
    assign in_fire  = InValid && InReady;
    assign out_fire = ovalid_q && OutReady;

    // The first element always lands at index 0; wr_q is only meaningful in LOAD.
    assign buf_we    = in_fire;
    assign buf_waddr = (state_q == IDLE) ? '0 : wr_q;
    // PREP fetches element 0; EMIT fetches the element after the one on Dataout.
    assign buf_raddr = (state_q == PREP) ? '0 : rd_q;

    softmax_vecbuf #(
        .W  (DATALENGTH),
        .AW (INPUTMAX)
    ) u_vecbuf (
        .clk_i   (Clock),
        .we_i    (buf_we),
        .waddr_i (buf_waddr),
        .wdata_i (Datain),
        .raddr_i (buf_raddr),
        .rdata_o (buf_rdata)
    );

`ifdef SOFTMAX_MAXSUB_SAT_EN
    // One extra bit holds the full range of x - max (down to -(2^32-1)).
    // Result is never positive, so only the negative overflow needs clamping:
    // sign set but the next bit clear means below -2^(DATALENGTH-1).
    logic [DATALENGTH:0] diff_wide;

    assign diff_wide = {buf_rdata[DATALENGTH-1], buf_rdata}
                     - {max_q[DATALENGTH-1], max_q};

    always_comb begin
        diff_res = diff_wide[DATALENGTH-1:0];
        if (diff_wide[DATALENGTH] && !diff_wide[DATALENGTH-1]) begin
            diff_res = {1'b1, {(DATALENGTH-1){1'b0}}};
        end
    end
`else
    // Low bits of the wide difference equal the plain modular subtraction.
    assign diff_res = buf_rdata - max_q;
`endif

    always_comb begin
        state_d  = state_q;
        len_d    = len_q;
        wr_d     = wr_q;
        rd_d     = rd_q;
        max_d    = max_q;
        dout_d   = dout_q;
        ovalid_d = ovalid_q;
        olast_d  = olast_q;

        case (state_q)
            IDLE: begin
                if (in_fire) begin
                    len_d   = N;
                    max_d   = Datain;
                    wr_d    = IDX_ONE;
                    state_d = (N == '0) ? PREP : LOAD;
                end
            end
            LOAD: begin
                if (in_fire) begin
                    // Strict compare keeps the earliest of equal values.
                    if ($signed(Datain) > $signed(max_q)) begin
                        max_d = Datain;
                    end
                    wr_d = wr_q + IDX_ONE;
                    if (wr_q == len_q) begin
                        state_d = PREP;
                    end
                end
            end
            PREP: begin
                dout_d   = diff_res;
                ovalid_d = 1'b1;
                olast_d  = (len_q == '0);
                rd_d     = IDX_ONE;
                state_d  = EMIT;
            end
            EMIT: begin
                if (out_fire) begin
                    if (olast_q) begin
                        ovalid_d = 1'b0;
                        olast_d  = 1'b0;
                        state_d  = IDLE;
                    end else begin
                        dout_d  = diff_res;
                        olast_d = (rd_q == len_q);
                        rd_d    = rd_q + IDX_ONE;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge Clock) begin
        if (!Reset) begin
            state_q  <= IDLE;
            len_q    <= '0;
            wr_q     <= '0;
            rd_q     <= '0;
            max_q    <= '0;
            dout_q   <= '0;
            ovalid_q <= 1'b0;
            olast_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            len_q    <= len_d;
            wr_q     <= wr_d;
            rd_q     <= rd_d;
            max_q    <= max_d;
            dout_q   <= dout_d;
            ovalid_q <= ovalid_d;
            olast_q  <= olast_d;
        end
    end

    assign Dataout  = dout_q;
    assign OutValid = ovalid_q;
    assign OutLast  = olast_q;

endmodule
